// File: rtl/fifo_level_core.sv
// fifo_level_core
// Synchronous FIFO core with a live fill count, programmable almost-full and
// almost-empty thresholds, a synchronous flush, sticky overflow/underflow
// flags and defined simultaneous read/write behaviour at full and empty.
//
// Compile-time option: define FIFO_FWFT_EN for first-word-fall-through reads
// (o_rdata shows the head entry combinationally). Left undefined, o_rdata is
// a register loaded on each accepted read.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rstn         asynchronous active-low reset
//   i_clr        synchronous flush (pointers, count and sticky flags to 0)
//   i_wen        write request
//   i_wdata      write data
//   o_wfull      count == 2**ALEN
//   o_wafull     count >= AFULL_TH
//   o_woverflow  sticky, a write was dropped
//   i_ren        read request
//   o_rdata      read data
//   o_rempty     count == 0
//   o_raempty    count <= AEMPTY_TH
//   o_runderflow sticky, a read was dropped
//   o_count      occupancy, 0..2**ALEN
module fifo_level_core #(
  parameter int ALEN      = 4,
  parameter int DLEN      = 8,
  parameter int AFULL_TH  = 2**ALEN - 4,
  parameter int AEMPTY_TH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_clr,
  input  logic            i_wen,
  input  logic [DLEN-1:0] i_wdata,
  output logic            o_wfull,
  output logic            o_wafull,
  output logic            o_woverflow,
  input  logic            i_ren,
  output logic [DLEN-1:0] o_rdata,
  output logic            o_rempty,
  output logic            o_raempty,
  output logic            o_runderflow,
  output logic [ALEN:0]   o_count
);

  localparam int DEPTH = 2**ALEN;
  localparam logic [ALEN:0] DEPTH_C   = (ALEN+1)'(DEPTH);
  localparam logic [ALEN:0] AFULL_C   = (ALEN+1)'(AFULL_TH);
  localparam logic [ALEN:0] AEMPTY_C  = (ALEN+1)'(AEMPTY_TH);

  logic [DLEN-1:0] mem [DEPTH];
  logic [ALEN:0]   wptr;
  logic [ALEN:0]   rptr;
  logic [ALEN:0]   count;
  logic            overflow;
  logic            underflow;
  logic            full;
  logic            empty;
  logic            racc;
  logic            wacc;

  // The extra pointer bit makes full (difference 2**ALEN) distinct from
  // empty (difference 0); the subtraction wraps naturally.
  assign count = wptr - rptr;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A read on an empty FIFO is never accepted, even if a write lands in the
  // same cycle. A write on a full FIFO is accepted only alongside a read,
  // which frees the slot being written. Flush masks both.
  assign racc = i_ren & ~empty & ~i_clr;
  assign wacc = i_wen & (~full | racc) & ~i_clr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (i_clr) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wacc) wptr <= wptr + 1'b1;
      if (racc) rptr <= rptr + 1'b1;
      if (i_wen && !wacc) overflow  <= 1'b1;
      if (i_ren && !racc) underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset; the pointer reset makes old contents
  // unreachable. When full with a simultaneous read, the write targets the
  // head slot, but the registered read samples the old value at the same edge.
  always_ff @(posedge clk) begin
    if (wacc) mem[wptr[ALEN-1:0]] <= i_wdata;
  end

`ifdef FIFO_FWFT_EN
  // Head entry is visible as soon as it is written; meaningless while empty.
  assign o_rdata = mem[rptr[ALEN-1:0]];
`else
  logic [DLEN-1:0] rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (racc) begin
      rdata <= mem[rptr[ALEN-1:0]];
    end
  end

  assign o_rdata = rdata;
`endif

  assign o_count      = count;
  assign o_wfull      = full;
  assign o_rempty     = empty;
  assign o_wafull     = (count >= AFULL_C);
  assign o_raempty    = (count <= AEMPTY_C);
  assign o_woverflow  = overflow;
  assign o_runderflow = underflow;

endmodule

// File: tb/tb_fifo_level_core.sv
// Self-checking bench for fifo_level_core (ALEN=4, DLEN=8, AFULL_TH=12,
// AEMPTY_TH=2). A queue-based reference model tracks contents, sticky flags
// and the expected read data; each scenario task compares the DUT with it.
module tb_fifo_level_core;

  localparam int ALEN = 4;
  localparam int DLEN = 8;
  localparam int DEPTH = 16;
  localparam int AFULL_TH = 12;
  localparam int AEMPTY_TH = 2;
`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            i_clr = 1'b0;
  logic            i_wen = 1'b0;
  logic [DLEN-1:0] i_wdata = '0;
  logic            i_ren = 1'b0;
  logic            o_wfull, o_wafull, o_woverflow;
  logic            o_rempty, o_raempty, o_runderflow;
  logic [DLEN-1:0] o_rdata;
  logic [ALEN:0]   o_count;

  fifo_level_core #(.ALEN(ALEN), .DLEN(DLEN), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)) dut (
    .clk(clk), .rstn(rstn), .i_clr(i_clr),
    .i_wen(i_wen), .i_wdata(i_wdata),
    .o_wfull(o_wfull), .o_wafull(o_wafull), .o_woverflow(o_woverflow),
    .i_ren(i_ren), .o_rdata(o_rdata),
    .o_rempty(o_rempty), .o_raempty(o_raempty), .o_runderflow(o_runderflow),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [DLEN-1:0] q[$];
  bit              m_ovf, m_udf;
  logic [DLEN-1:0] exp_rdata;
  bit              rdv;
  int              n_cmp = 0;
  int              n_err = 0;
  logic [7:0]      pat = 8'h00;

  function automatic void model_reset();
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    exp_rdata = '0;
    rdv = !FWFT;
  endfunction

  function automatic void model_cycle(bit wen, bit ren, bit clr, logic [DLEN-1:0] d);
    bit ra, wa;
    if (clr) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      ra = ren && (q.size() > 0);
      wa = wen && ((q.size() < DEPTH) || ra);
      if (ren && !ra) m_udf = 1;
      if (wen && !wa) m_ovf = 1;
      if (ra) begin
        if (!FWFT) exp_rdata = q[0];
        void'(q.pop_front());
      end
      if (wa) q.push_back(d);
    end
    if (FWFT) begin
      rdv = (q.size() > 0);
      if (rdv) exp_rdata = q[0];
    end
  endfunction

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input bit wen, input bit ren, input bit clr, input logic [DLEN-1:0] d);
    i_wen = wen; i_ren = ren; i_clr = clr; i_wdata = d;
    @(posedge clk);
    model_cycle(wen, ren, clr, d);
    #1;
    i_wen = 1'b0; i_ren = 1'b0; i_clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    n_cmp++; if (o_count !== 5'd0 || o_rempty !== 1'b1 || o_raempty !== 1'b1 || o_wfull !== 1'b0 || o_wafull !== 1'b0)
      begin n_err++; $display("FAIL reset_init: count=%0d empty=%b aempty=%b full=%b afull=%b want 0 1 1 0 0", o_count, o_rempty, o_raempty, o_wfull, o_wafull); end
    n_cmp++; if (o_rdata !== 8'h00 && !FWFT) begin n_err++; $display("FAIL reset_init_rdata: got %h want 00", o_rdata); end
    // Build count=5 with a nonzero read register, then reset mid-burst.
    for (int i = 0; i < 6; i++) step(1, 0, 0, 8'h50 + 8'(i));
    step(0, 1, 0, 8'h00);
    n_cmp++; if (o_count !== 5'(q.size())) begin n_err++; $display("FAIL reset_pre_count: got %0d want %0d", o_count, q.size()); end
    i_wen = 1'b1; i_wdata = 8'hEE;
    #3 rstn = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (o_count !== 5'd0 || o_rempty !== 1'b1 || o_raempty !== 1'b1 || o_woverflow !== 1'b0 || o_runderflow !== 1'b0)
      begin n_err++; $display("FAIL reset_async: count=%0d empty=%b aempty=%b ovf=%b udf=%b want 0 1 1 0 0", o_count, o_rempty, o_raempty, o_woverflow, o_runderflow); end
    n_cmp++; if (rdv && o_rdata !== exp_rdata) begin n_err++; $display("FAIL reset_async_rdata: got %h want %h", o_rdata, exp_rdata); end
    @(posedge clk);
    #1 i_wen = 1'b0; rstn = 1'b1;
    n_cmp++; if (o_count !== 5'd0) begin n_err++; $display("FAIL reset_hold_count: got %0d want 0", o_count); end
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    step(1, 0, 0, 8'hA5);
    n_cmp++; if (o_count !== 5'd1 || o_rempty !== 1'b0) begin n_err++; $display("FAIL single_write: count=%0d empty=%b want 1 0", o_count, o_rempty); end
    n_cmp++; if (rdv && o_rdata !== exp_rdata) begin n_err++; $display("FAIL single_fwft_rdata: got %h want %h", o_rdata, exp_rdata); end
    step(0, 1, 0, 8'h00);
    n_cmp++; if (o_rempty !== 1'b1 || (!FWFT && o_rdata !== 8'hA5)) begin n_err++; $display("FAIL single_read: rdata=%h empty=%b want a5 1", o_rdata, o_rempty); end
    $display("test_single_word done: rdata=%h", o_rdata);
  endtask

  task automatic test_thresholds();
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 8'($urandom_range(0, 255)));
      n_cmp++;
      if (o_count !== 5'(q.size()) || o_raempty !== (q.size() <= AEMPTY_TH) ||
          o_wafull !== (q.size() >= AFULL_TH) || o_wfull !== (q.size() == DEPTH))
        begin n_err++; $display("FAIL thresh_fill: count=%0d aempty=%b afull=%b full=%b want count %0d", o_count, o_raempty, o_wafull, o_wfull, q.size()); end
    end
    step(1, 0, 0, 8'hFF);
    n_cmp++; if (o_woverflow !== 1'b1 || o_count !== 5'd16) begin n_err++; $display("FAIL thresh_overflow: ovf=%b count=%0d want 1 16", o_woverflow, o_count); end
    $display("test_thresholds done: count=%0d", o_count);
  endtask

  task automatic test_full_boundary();
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin step(1, 0, 0, pat); pat++; end
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, pat); pat++;
      n_cmp++;
      if (o_count !== 5'd16 || o_woverflow !== 1'b0 || (rdv && o_rdata !== exp_rdata))
        begin n_err++; $display("FAIL full_rw: count=%0d ovf=%b rdata=%h want 16 0 %h", o_count, o_woverflow, o_rdata, exp_rdata); end
    end
    $display("test_full_boundary done: rdata=%h", o_rdata);
  endtask

  task automatic test_empty_boundary();
    step(0, 0, 1, 8'h00);
    step(1, 1, 0, 8'h3C);
    n_cmp++; if (o_runderflow !== 1'b1 || o_count !== 5'd1) begin n_err++; $display("FAIL empty_rw: udf=%b count=%0d want 1 1", o_runderflow, o_count); end
    step(0, 1, 0, 8'h00);
    n_cmp++; if (o_count !== 5'd0 || (!FWFT && o_rdata !== 8'h3C)) begin n_err++; $display("FAIL empty_readback: rdata=%h count=%0d want 3c 0", o_rdata, o_count); end
    $display("test_empty_boundary done");
  endtask

  task automatic test_flush();
    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 8'(i));
    for (int i = 0; i < 9; i++) step(0, 1, 0, 8'h00);
    n_cmp++; if (o_count !== 5'd7 || o_woverflow !== 1'b1 || o_runderflow !== 1'b1)
      begin n_err++; $display("FAIL flush_setup: count=%0d ovf=%b udf=%b want 7 1 1", o_count, o_woverflow, o_runderflow); end
    step(1, 0, 1, 8'h99);
    n_cmp++; if (o_count !== 5'd0 || o_rempty !== 1'b1 || o_woverflow !== 1'b0 || o_runderflow !== 1'b0)
      begin n_err++; $display("FAIL flush: count=%0d empty=%b ovf=%b udf=%b want 0 1 0 0", o_count, o_rempty, o_woverflow, o_runderflow); end
    n_cmp++; if (rdv && o_rdata !== exp_rdata) begin n_err++; $display("FAIL flush_rdata_hold: got %h want %h", o_rdata, exp_rdata); end
    $display("test_flush done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), ($urandom_range(0, 39) == 0),
           8'($urandom_range(0, 255)));
      n_cmp++;
      if (o_count !== 5'(q.size()) || o_rempty !== (q.size() == 0) || o_wfull !== (q.size() == DEPTH) ||
          o_raempty !== (q.size() <= AEMPTY_TH) || o_wafull !== (q.size() >= AFULL_TH) ||
          o_woverflow !== m_ovf || o_runderflow !== m_udf || (rdv && o_rdata !== exp_rdata))
        begin
          n_err++;
          $display("FAIL random[%0d]: count=%0d ovf=%b udf=%b rdata=%h want count=%0d ovf=%b udf=%b rdata=%h",
                   i, o_count, o_woverflow, o_runderflow, o_rdata, q.size(), m_ovf, m_udf, exp_rdata);
        end
    end
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_word();
    test_thresholds();
    test_full_boundary();
    test_empty_boundary();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_level_core.md
# fifo_level_core

Parametrised synchronous FIFO core that succeeds the basic FIFO core in the AXI-Stream FIFO datapath. It adds a live fill count, programmable almost-full/almost-empty thresholds, a synchronous flush and defined simultaneous read/write behaviour at the full and empty boundaries. An optional first-word-fall-through read mode is selected at compile time. It sits directly under the AXI-Stream adapter, which maps tvalid/tready onto i_wen/i_ren.

## Interface
- ALEN, 4: address width; depth = 2**ALEN entries.
- DLEN, 8: data width in bits.
- AFULL_TH, 2**ALEN-4: o_wafull asserts when count >= AFULL_TH; legal range 1..2**ALEN.
- AEMPTY_TH, 2: o_raempty asserts when count <= AEMPTY_TH; legal range 0..2**ALEN-1.

- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- i_clr  in  1  synchronous flush.
- i_wen  in  1  write request.
- i_wdata  in  DLEN  write data.
- o_wfull  out  1  count == 2**ALEN.
- o_wafull  out  1  almost full.
- o_woverflow  out  1  sticky: a write was dropped.
- i_ren  in  1  read request.
- o_rdata  out  DLEN  read data.
- o_rempty  out  1  count == 0.
- o_raempty  out  1  almost empty.
- o_runderflow  out  1  sticky: a read was dropped.
- o_count  out  ALEN+1  current occupancy, 0..2**ALEN.

## Operation
- Storage: 2**ALEN x DLEN register array, not reset.
- Pointers: write and read pointers are ALEN+1 bits and wrap modulo 2**(ALEN+1). The low ALEN bits index the array. o_count equals wptr - rptr, computed modulo 2**(ALEN+1).
- Write acceptance: wacc = i_wen & (!o_wfull | racc).
  - A write while full with no accepted read is dropped and sets o_woverflow.
- Read acceptance: racc = i_ren & !o_rempty.
  - A read while empty is dropped and sets o_runderflow. This holds even if i_wen is high in the same cycle.
- Simultaneous events:
  - Full with i_wen and i_ren: both are accepted, count is unchanged, no overflow.
  - Empty with i_wen and i_ren: the write is accepted, the read is dropped, underflow is set, count becomes 1.
- Count update: count += wacc - racc.
- Flags: o_wfull, o_wafull, o_rempty and o_raempty are decoded from the registered count. They change only after the clock edge that changed count.
- Sticky flags: o_woverflow and o_runderflow clear only on rstn low or i_clr.
- i_clr behaviour:
  - On the next edge, pointers, count and both sticky flags go to 0.
  - i_wen and i_ren in that cycle are ignored and set no flags.
  - o_rdata is held (registered mode).
- Reset (asynchronous, any time, including mid-burst):
  - o_count = 0, o_rempty = 1, o_raempty = 1, o_wfull = 0.
  - o_wafull = 0 unless AFULL_TH == 0.
  - o_woverflow = 0, o_runderflow = 0, o_rdata = 0.
  - Contents before reset are never readable afterwards.

## Timing
- Write-to-visible latency: an entry written at edge N makes o_rempty low and o_count increment after edge N.
- Registered read mode (default):
  - When racc, o_rdata is loaded from the head entry at that edge, i.e. valid one cycle after i_ren is sampled.
  - o_rdata holds its last value when no read is accepted, including on a dropped read.
- Throughput: one write and one read per cycle sustained, with no bubbles at the wrap-around of either pointer.
- The sticky flags assert after the edge that dropped the request.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - o_rdata is driven combinationally from the head entry whenever o_rempty is low; i_ren pops it.
  - The first written word appears on o_rdata after the write edge, with no read needed.
  - o_rdata is don't-care while o_rempty is high.
  - Flag, count and acceptance rules are unchanged.
- FIFO_FWFT_EN undefined: registered read mode, as described under Timing.

## Test plan
All scenarios use ALEN=4, DLEN=8, AFULL_TH=12, AEMPTY_TH=2.
- Reset: assert rstn low mid-burst with count=5 -> immediately o_count=0, o_rempty=1, o_raempty=1, o_rdata=0x00, both sticky flags 0.
- Single word: write 0xA5, then pulse i_ren -> registered mode: o_rdata=0xA5 the cycle after i_ren. FWFT build: o_rdata=0xA5 one cycle after the write; o_rempty=1 after the pop.
- Thresholds: write 16 random bytes -> o_raempty drops at count=3, o_wafull rises at count=12, o_wfull at 16. Then issue a 17th write -> o_woverflow=1 and o_count stays 16.
- Full boundary: with count=16, hold i_wen and i_ren for 20 cycles with an incrementing pattern -> count stays 16, no overflow, data returned in order across pointer wrap.
- Empty boundary: with count=0, raise i_wen and i_ren together with data 0x3C -> o_runderflow=1, o_count=1. The next read returns 0x3C.
- Flush: at count=7 with both sticky flags set, pulse i_clr together with i_wen -> next cycle o_count=0, o_rempty=1, sticky flags 0, and the write is not stored.
